cache_fill_ctrl: RTL

- Initiator-side controller for the 4-cycle-read, single-cycle-write 16-bit memory (memory4c).
- On a cache miss it fetches one cache block from memory. It pipelines one read request per cycle, collects the in-order responses, and drives the cache data array writes and the final tag write.
- When idle it forwards write-through stores to memory as single-cycle writes.
- Sits between the I/D cache and the memory model.

---
 rtl/cache_fill_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/cache_fill_ctrl.sv
// Block-fill controller between the I/D cache and memory4c: pipelines one read per cycle on a miss and forwards write-through stores.
// Optional macro CRITICAL_WORD_FIRST_EN: fetch starts at the missing word and adds the crit_word_valid pulse.
module cache_fill_ctrl #(
  parameter int ADDR_WIDTH  = 16,
  parameter int BLOCK_WORDS = 8,
  parameter int MEM_LATENCY = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          miss_detected,
  input  logic [ADDR_WIDTH-1:0]         miss_address,
  input  logic                          st_req,
  input  logic [ADDR_WIDTH-1:0]         st_addr,
  input  logic [15:0]                   st_data,
  output logic                          st_ready,
  output logic                          fsm_busy,
  output logic                          mem_enable,
  output logic                          mem_wr,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [15:0]                   mem_data_in,
  input  logic                          mem_data_valid,
  input  logic [15:0]                   mem_data_out,
  output logic                          write_data_array,
  output logic [$clog2(BLOCK_WORDS)-1:0] cache_word_idx,
  output logic [15:0]                   cache_data,
  output logic                          write_tag_array,
  output logic                          fill_done
`ifdef CRITICAL_WORD_FIRST_EN
  , output logic                        crit_word_valid
`endif
);

  localparam int W = $clog2(BLOCK_WORDS);
  localparam logic [W:0]            LAST_CNT = (W+1)'(BLOCK_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] BLK_MASK = ADDR_WIDTH'((1 << (W + 1)) - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [W:0]            r_iss_cnt;
  logic [W:0]            r_rsp_cnt;
  logic [W-1:0]          w_crit;

`ifdef CRITICAL_WORD_FIRST_EN
  logic [W-1:0] r_crit;
  assign w_crit = r_crit;
`else
  assign w_crit = '0;
`endif

  logic                  w_idle;
  logic                  w_st_go;
  logic                  w_rsp;
  logic                  w_last;
  logic [W-1:0]          w_req_word;
  logic [W-1:0]          w_rsp_word;
  logic [ADDR_WIDTH-1:0] w_req_addr;

  // Word indices wrap naturally in W bits, which gives the modulo for wrapped fetch order.
  assign w_req_word = r_iss_cnt[W-1:0] + w_crit;
  assign w_rsp_word = r_rsp_cnt[W-1:0] + w_crit;
  assign w_req_addr = r_base | ADDR_WIDTH'({w_req_word, 1'b0});

  assign w_idle  = (r_state == IDLE);
  assign w_st_go = ~rst & w_idle & ~miss_detected & st_req;
  assign w_rsp   = ~rst & ~w_idle & mem_data_valid;
  assign w_last  = w_rsp & (r_state == DRAIN) & (r_rsp_cnt == LAST_CNT);

  assign st_ready         = w_st_go;
  assign fsm_busy         = ~w_idle;
  assign mem_enable       = w_st_go | (~rst & (r_state == ISSUE));
  assign mem_wr           = w_st_go;
  assign mem_data_in      = w_st_go ? st_data : 16'h0000;
  assign write_data_array = w_rsp;
  assign cache_word_idx   = w_rsp ? w_rsp_word : '0;
  assign cache_data       = w_rsp ? mem_data_out : 16'h0000;
  assign write_tag_array  = w_last;
  assign fill_done        = w_last;
`ifdef CRITICAL_WORD_FIRST_EN
  assign crit_word_valid  = w_rsp & (r_rsp_cnt == '0);
`endif

  always_comb begin
    mem_addr = '0;
    if (w_st_go)
      mem_addr = st_addr & ~ADDR_WIDTH'(1);
    else if (~rst && r_state == ISSUE)
      mem_addr = w_req_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_iss_cnt <= '0;
      r_rsp_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (miss_detected) begin
            r_iss_cnt <= '0;
            r_rsp_cnt <= '0;
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          r_iss_cnt <= r_iss_cnt + 1'b1;
          if (r_iss_cnt == LAST_CNT)
            r_state <= DRAIN;
          if (w_rsp)
            r_rsp_cnt <= r_rsp_cnt + 1'b1;
        end
        DRAIN: begin
          if (w_rsp)
            r_rsp_cnt <= r_rsp_cnt + 1'b1;
          if (w_last)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Block address and start word are datapath captures; they need no reset.
  always_ff @(posedge clk) begin
    if (w_idle && miss_detected) begin
      r_base <= miss_address & ~BLK_MASK;
`ifdef CRITICAL_WORD_FIRST_EN
      r_crit <= miss_address[W:1];
`endif
    end
  end

`ifndef SYNTHESIS
  logic [W:0] w_outstanding;
  assign w_outstanding = r_iss_cnt - r_rsp_cnt;

  // More reads in flight than the memory latency means responses are missing or duplicated.
  always @(posedge clk) begin
    if (!rst && !w_idle)
      assert (int'(w_outstanding) <= MEM_LATENCY)
        else $error("cache_fill_ctrl: %0d reads outstanding exceeds latency %0d", w_outstanding, MEM_LATENCY);
  end
`endif

endmodule
